scaler_v_linebuf: RTL

Vertical tap line buffer between the horizontal cubic scaler (`scaler_h`) and the vertical cubic filter. It stores the three most recent horizontally scaled lines in block RAM. For every incoming pixel it presents a column-aligned 4-tap vector: the current line plus lines n-1, n-2 and n-3. Taps that would reach above the top of the frame are forced to zero.

---
 rtl/scaler_pkg.sv | 26 ++
 rtl/scaler_line_ram.sv | 27 ++
 rtl/scaler_v_linebuf.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/scaler_pkg.sv
// Shared definitions for the scaler datapath: tap count, default pixel width,
// line-buffer FSM states and tap bus slice/pack helpers used by the vertical stages.
package scaler_pkg;

  localparam int TAPS            = 4;
  localparam int PIXEL_WIDTH_DEF = 12;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } lb_state_e;

  typedef logic [PIXEL_WIDTH_DEF-1:0]      pixel_t;
  typedef logic [TAPS*PIXEL_WIDTH_DEF-1:0] tap_bus_t;

  // Tap k of a packed bus: 0 is the current line, 3 is the oldest.
  function automatic pixel_t tap_get(input tap_bus_t bus, input int k);
    return bus[k*PIXEL_WIDTH_DEF +: PIXEL_WIDTH_DEF];
  endfunction

  function automatic tap_bus_t tap_pack(input pixel_t t0, input pixel_t t1,
                                        input pixel_t t2, input pixel_t t3);
    return {t3, t2, t1, t0};
  endfunction

endpackage

// File: rtl/scaler_line_ram.sv
// Single-port read-first line RAM with synchronous 1-cycle read, one line deep.
module scaler_line_ram
  import scaler_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int LINE_MAX    = 4096
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic                        we,
  input  logic [$clog2(LINE_MAX)-1:0] addr,
  input  logic [PIXEL_WIDTH-1:0]      wdata,
  output logic [PIXEL_WIDTH-1:0]      rdata
);

  logic [PIXEL_WIDTH-1:0] mem [LINE_MAX];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) begin
        mem[addr] <= wdata;
      end
    end
  end

endmodule

// File: rtl/scaler_v_linebuf.sv
// Vertical tap line buffer: keeps the three previous lines in rotating RAMs and
// emits a column-aligned 4-tap vector per pixel, zeroing taps above the frame top.
module scaler_v_linebuf
  import scaler_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int LINE_MAX    = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PIXEL_WIDTH-1:0]      di_i,
  input  logic                        de_i,
  input  logic                        hs_i,
  input  logic                        vs_i,
  output logic [TAPS*PIXEL_WIDTH-1:0] do_o,
  output logic                        de_o,
  output logic                        hs_o,
  output logic                        vs_o,
  output logic [15:0]                 line_o,
  output logic                        err_o
);

  localparam int            AW      = $clog2(LINE_MAX);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] COL_LIM = CW'(LINE_MAX);

  function automatic logic [1:0] wsel_inc(input logic [1:0] w);
    return (w == 2'd2) ? 2'd0 : w + 2'd1;
  endfunction

  function automatic logic [1:0] wsel_dec(input logic [1:0] w);
    return (w == 2'd0) ? 2'd2 : w - 2'd1;
  endfunction

  function automatic logic [1:0] vcnt_inc_sat(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  function automatic logic [15:0] line_inc_sat(input logic [15:0] l);
    return (l == 16'hFFFF) ? l : l + 16'd1;
  endfunction

  function automatic logic [CW-1:0] col_inc_sat(input logic [CW-1:0] c);
    return (c == COL_LIM) ? c : c + CW'(1);
  endfunction

  function automatic logic [PIXEL_WIDTH-1:0] ram_pick(input logic [1:0] sel,
                                                      input logic [PIXEL_WIDTH-1:0] a0,
                                                      input logic [PIXEL_WIDTH-1:0] a1,
                                                      input logic [PIXEL_WIDTH-1:0] a2);
    case (sel)
      2'd0:    return a0;
      2'd1:    return a1;
      default: return a2;
    endcase
  endfunction

  lb_state_e        state_q, state_d;
  logic [CW-1:0]    col_q;
  logic [1:0]       wsel_q;
  logic [1:0]       vcnt_q;
  logic [15:0]      line_q;
  logic             err_q;

  logic             sof, acc, sol, keep;
  logic [CW-1:0]    col_cur;
  logic [1:0]       wsel_cur;
  logic [1:0]       vcnt_cur;
  logic [15:0]      line_cur;

  // Input stage: qualify the pixel and resolve its column, RAM bank and line index
  assign sof      = de_i & hs_i & vs_i;
  assign acc      = de_i & ((state_q == RUN) | sof);
  assign sol      = acc & hs_i;
  assign col_cur  = sol ? '0 : col_q;
  assign keep     = acc & (col_cur < COL_LIM);
  assign wsel_cur = sol ? wsel_inc(wsel_q) : wsel_q;
  assign vcnt_cur = (acc & sof) ? 2'd0  : (sol ? vcnt_inc_sat(vcnt_q) : vcnt_q);
  assign line_cur = (acc & sof) ? 16'd0 : (sol ? line_inc_sat(line_q) : line_q);

  always_comb begin
    state_d = state_q;
    if ((state_q == WAIT_SOF) && sof) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_SOF;
      col_q   <= '0;
      wsel_q  <= 2'd0;
      vcnt_q  <= 2'd0;
      line_q  <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        col_q  <= col_inc_sat(col_cur);
        wsel_q <= wsel_cur;
        vcnt_q <= vcnt_cur;
        line_q <= line_cur;
        if (sof) begin
          err_q <= 1'b0;
        end else if (!keep) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // Stage p0: RAM read-first access, pixel and context registered alongside
  logic [PIXEL_WIDTH-1:0] q_p0 [3];
  logic [PIXEL_WIDTH-1:0] di_p0;
  logic [1:0]             wsel_p0;
  logic [1:0]             vcnt_p0;
  logic [15:0]            line_p0;
  logic                   vld_p0, hs_p0, vs_p0;

  for (genvar i = 0; i < 3; i++) begin : g_ram
    scaler_line_ram #(
      .PIXEL_WIDTH (PIXEL_WIDTH),
      .LINE_MAX    (LINE_MAX)
    ) u_ram (
      .clk   (clk),
      .en    (keep),
      .we    (keep && (wsel_cur == 2'(i))),
      .addr  (col_cur[AW-1:0]),
      .wdata (di_i),
      .rdata (q_p0[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      hs_p0  <= 1'b0;
      vs_p0  <= 1'b0;
    end else begin
      vld_p0 <= keep;
      hs_p0  <= keep & hs_i;
      vs_p0  <= keep & vs_i;
    end
  end

  always_ff @(posedge clk) begin
    if (keep) begin
      di_p0   <= di_i;
      wsel_p0 <= wsel_cur;
      vcnt_p0 <= vcnt_cur;
      line_p0 <= line_cur;
    end
  end

  // Stage p1: map banks to line age, mask taps above the frame top, register outputs
  logic [PIXEL_WIDTH-1:0] tap1_p0, tap2_p0, tap3_p0;

  assign tap1_p0 = (vcnt_p0 != 2'd0) ? ram_pick(wsel_dec(wsel_p0), q_p0[0], q_p0[1], q_p0[2]) : '0;
  assign tap2_p0 = vcnt_p0[1]        ? ram_pick(wsel_inc(wsel_p0), q_p0[0], q_p0[1], q_p0[2]) : '0;
  assign tap3_p0 = (vcnt_p0 == 2'd3) ? ram_pick(wsel_p0,           q_p0[0], q_p0[1], q_p0[2]) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do_o   <= '0;
      de_o   <= 1'b0;
      hs_o   <= 1'b0;
      vs_o   <= 1'b0;
      line_o <= 16'd0;
    end else begin
      de_o <= vld_p0;
      hs_o <= hs_p0;
      vs_o <= vs_p0;
      if (vld_p0) begin
        do_o   <= {tap3_p0, tap2_p0, tap1_p0, di_p0};
        line_o <= line_p0;
      end
    end
  end

  assign err_o = err_q;

endmodule
